// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command front-end.
// Opcodes, FSM encoding and response flag positions.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int FLG_CARRY = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_ERR   = 2;
  localparam int FLG_W     = 3;

endpackage

// File: rtl/alu_exec_unit.sv
// Combinational 4-bit ALU function.
// Reserved opcodes give Y=0, carry=0 and raise err.
module alu_exec_unit
  import alu_seq_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] y_o,
  output logic       carry_o,
  output logic       err_o
);

  // Opcode decode and arithmetic
  always_comb begin
    y_o     = 4'h0;
    carry_o = 1'b0;
    err_o   = 1'b0;
    case (op_i)
      OP_ADD: {carry_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB: begin
        y_o     = a_i - b_i;
        carry_o = (a_i < b_i);
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential command front-end for the 4-bit ALU.
// IDLE accepts, EXEC computes, RESP holds until consumed.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter logic [3:0] ACC_INIT = 4'h0,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [3:0]       req_a,
  input  logic [3:0]       req_b,
  input  logic             req_use_acc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_y,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [3:0]       acc,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [3:0]         a_q, a_d;
  logic [3:0]         b_q, b_d;
  logic [3:0]         y_q, y_d;
  logic [FLG_W-1:0]   flg_q, flg_d;
  logic [3:0]         acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]         ex_y;
  logic               ex_c;
  logic               ex_err;

  alu_exec_unit u_exec (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .y_o     (ex_y),
    .carry_o (ex_c),
    .err_o   (ex_err)
  );

  // Next-state, capture and result/update logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    y_d       = y_q;
    flg_d     = flg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_use_acc ? acc_q : req_a;
          b_d     = req_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        y_d              = ex_y;
        flg_d[FLG_CARRY] = ex_c;
        flg_d[FLG_ZERO]  = !ex_err && (ex_y == 4'h0);
        flg_d[FLG_ERR]   = ex_err;
        if (!ex_err) begin
          acc_d = ex_y;
          if (cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      y_q     <= 4'h0;
      flg_q   <= '0;
      acc_q   <= ACC_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      flg_q   <= flg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_y     = y_q;
  assign rsp_carry = flg_q[FLG_CARRY];
  assign rsp_zero  = flg_q[FLG_ZERO];
  assign rsp_err   = flg_q[FLG_ERR];
  assign acc       = acc_q;
  assign op_count  = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule
